// File: rtl/edge_pipeline_sequencer.sv
// edge_pipeline_sequencer
// Sequences the Sobel edge-detection datapath in the core clock domain.
// Requests from the colorspace converter are dispatched one at a time,
// with a one-entry pending slot behind the active transaction. Border
// pixels bypass the Sobel unit and produce 0. Interior pixels start the
// Sobel unit and wait for done or a timeout. Each result leaves as a
// one-cycle valid pixel; pixel (0,0) also raises frame_start.
// A vsync-framed pixel counter flags frames with the wrong pixel count.
//
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   enable          launch enable; low drops requests and clears pending
//   clr_err         clears the sticky error flags
//   vsync           pixel-domain vsync (2-flop synchronized here)
//   matrix_ready    request pulse, qualifies row/col
//   row, col        matrix centre coordinates
//   sobel_done      Sobel completion, qualifies sobel_out
//   sobel_out       Sobel magnitude
//   sobel_start     one-cycle Sobel start
//   pix, pix_valid  result pixel and strobe (pix holds between results)
//   frame_start     strobe with pix_valid for pixel (0,0)
//   busy            controller not idle
//   overrun         sticky: request dropped, pending slot was full
//   timeout         sticky: Sobel did not answer in time
//   frame_err       sticky: wrong pixel count between vsync edges
module edge_pipeline_sequencer #(
   parameter int unsigned HACT    = 640,
   parameter int unsigned VACT    = 480,
   parameter int unsigned TIMEOUT = 31,
   parameter int unsigned COL_W   = $clog2(HACT),
   parameter int unsigned ROW_W   = $clog2(VACT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clr_err,
   input  logic             vsync,
   input  logic             matrix_ready,
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] col,
   input  logic             sobel_done,
   input  logic [7:0]       sobel_out,
   output logic             sobel_start,
   output logic [7:0]       pix,
   output logic             pix_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             overrun,
   output logic             timeout,
   output logic             frame_err
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W = 19;
   localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(HACT * VACT);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(VACT - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(HACT - 1);
   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, EMIT} state_t;

   state_t             state;
   logic               pend_vld;
   logic [ROW_W-1:0]   pend_row;
   logic [COL_W-1:0]   pend_col;
   logic [ROW_W-1:0]   cur_row;
   logic [COL_W-1:0]   cur_col;
   logic [TMR_W-1:0]   timer;
   logic [CNT_W-1:0]   pix_cnt;
   logic [2:0]         vs_sync;

   logic               sel_vld;
   logic [ROW_W-1:0]   sel_row;
   logic [COL_W-1:0]   sel_col;
   logic               sel_border;
   logic               vs_edge;
   logic               emit_now;
   logic               set_ovr;
   logic               set_tmo;
   logic               set_ferr;

   // Source selection (pending before new pulse) and error-set events
   always_comb begin
      sel_vld    = enable && (pend_vld || matrix_ready);
      sel_row    = pend_vld ? pend_row : row;
      sel_col    = pend_vld ? pend_col : col;
      sel_border = (sel_row == '0) || (sel_row == ROW_LAST) ||
                   (sel_col == '0) || (sel_col == COL_LAST);
      vs_edge    = vs_sync[1] && !vs_sync[2];
      emit_now   = (state == EMIT);
      set_ovr    = (state != IDLE) && enable && matrix_ready && pend_vld;
      // done has priority over an expiring timer
      set_tmo    = (state == WAIT_DONE) && !sobel_done && (timer == TMR_MAX);
      set_ferr   = vs_edge && (pix_cnt != '0) && (pix_cnt != FRAME_PIX);
   end

   // Sequencer FSM, pending slot, frame counter and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pend_vld    <= 1'b0;
         pend_row    <= '0;
         pend_col    <= '0;
         cur_row     <= '0;
         cur_col     <= '0;
         timer       <= '0;
         pix_cnt     <= '0;
         vs_sync     <= '0;
         sobel_start <= 1'b0;
         pix         <= '0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         timeout     <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         sobel_start <= 1'b0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         vs_sync     <= {vs_sync[1:0], vsync};

         // Pending slot: cleared while disabled; refilled when consumed
         // together with a new pulse; filled by pulses arriving while busy
         if (!enable) begin
            pend_vld <= 1'b0;
         end else if (state == IDLE) begin
            if (pend_vld) begin
               pend_vld <= matrix_ready;
               if (matrix_ready) begin
                  pend_row <= row;
                  pend_col <= col;
               end
            end
         end else if (matrix_ready && !pend_vld) begin
            pend_vld <= 1'b1;
            pend_row <= row;
            pend_col <= col;
         end

         case (state)
            IDLE: begin
               if (sel_vld) begin
                  cur_row <= sel_row;
                  cur_col <= sel_col;
                  busy    <= 1'b1;
                  if (sel_border) begin
                     state       <= EMIT;
                     pix         <= '0;
                     pix_valid   <= 1'b1;
                     frame_start <= (sel_row == '0) && (sel_col == '0);
                  end else begin
                     state       <= ISSUE;
                     sobel_start <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (sobel_done || (timer == TMR_MAX)) begin
                  state       <= EMIT;
                  pix         <= sobel_done ? sobel_out : 8'h00;
                  pix_valid   <= 1'b1;
                  frame_start <= (cur_row == '0) && (cur_col == '0);
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            EMIT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         // Frame check; an emit coinciding with the edge opens the new frame
         if (vs_edge) begin
            pix_cnt <= emit_now ? CNT_W'(1) : '0;
         end else if (emit_now) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
         end

         overrun   <= set_ovr  || (overrun   && !clr_err);
         timeout   <= set_tmo  || (timeout   && !clr_err);
         frame_err <= set_ferr || (frame_err && !clr_err);
      end
   end

endmodule
